// File: rtl/turtle_data_memory_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | turtle_data_memory_if : Turtle core data-memory bus (addr/wdata/we/rdata)|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface turtle_data_memory_if #(
    parameter int DATA_W   = 8,
    parameter int D_ADDR_W = 12
);
    logic [D_ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0]   write_data;
    logic                data_memory_write_enable;
    logic [DATA_W-1:0]   read_data;

    modport master (
        output data_addr,
        output write_data,
        output data_memory_write_enable,
        input  read_data
    );

    modport slave (
        input  data_addr,
        input  write_data,
        input  data_memory_write_enable,
        output read_data
    );
endinterface
`default_nettype wire

// File: rtl/turtle_data_memory.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | turtle_data_memory : byte RAM + MMIO page (GPIO, timer, UART TX)       |
// | UART transmitter present only when TURTLE_DMEM_UART_EN is defined.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module turtle_data_memory #(
    parameter int DATA_W       = 8,
    parameter int D_ADDR_W     = 12,
    parameter int RAM_DEPTH    = 3840,
    parameter int CLKS_PER_BIT = 868,
    parameter int GPIO_W       = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    turtle_data_memory_if.slave     bus,
    output logic [GPIO_W-1:0]       gpio_out,
    input  wire logic [GPIO_W-1:0]  gpio_in,
    output logic                    uart_tx,
    output logic                    uart_busy
);
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [D_ADDR_W-1:0] C_GPIO_OUT  = D_ADDR_W'('hF00);
    localparam logic [D_ADDR_W-1:0] C_GPIO_IN   = D_ADDR_W'('hF01);
    localparam logic [D_ADDR_W-1:0] C_TIMER_LO  = D_ADDR_W'('hF02);
    localparam logic [D_ADDR_W-1:0] C_TIMER_HI  = D_ADDR_W'('hF03);
    localparam logic [D_ADDR_W-1:0] C_UART_STAT = D_ADDR_W'('hF05);

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] gpio_sync1_q;
    logic [GPIO_W-1:0] gpio_sync2_q;
    logic [15:0]       timer_q;
    logic [15:0]       timer_d;
    logic [15:0]       snap_q;

    logic              w_we;
    logic              w_ram_hit;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [DATA_W-1:0] w_rdata;

    assign w_we      = bus.data_memory_write_enable;
    assign w_ram_hit = 32'(bus.data_addr) < 32'(RAM_DEPTH);
    assign w_ram_idx = bus.data_addr[RAM_AW-1:0];

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_we && w_ram_hit) begin
            mem_q[w_ram_idx] <= bus.write_data;
        end
    end

    // A clear write wins over the free-running increment.
    always_comb begin
        timer_d = timer_q + 16'd1;
        if (w_we && (bus.data_addr == C_TIMER_HI)) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gpio_out_q   <= '0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
            timer_q      <= '0;
            snap_q       <= '0;
        end else begin
            gpio_sync1_q <= gpio_in;
            gpio_sync2_q <= gpio_sync1_q;
            timer_q      <= timer_d;
            if (w_we && (bus.data_addr == C_GPIO_OUT)) begin
                gpio_out_q <= bus.write_data[GPIO_W-1:0];
            end
            if (w_we && (bus.data_addr == C_TIMER_LO)) begin
                snap_q <= timer_q;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ram_hit) begin
            w_rdata = mem_q[w_ram_idx];
        end else begin
            case (bus.data_addr)
                C_GPIO_OUT:  w_rdata = DATA_W'(gpio_out_q);
                C_GPIO_IN:   w_rdata = DATA_W'(gpio_sync2_q);
                C_TIMER_LO:  w_rdata = DATA_W'(snap_q[7:0]);
                C_TIMER_HI:  w_rdata = DATA_W'(snap_q[15:8]);
                C_UART_STAT: w_rdata = DATA_W'(uart_busy);
                default:     w_rdata = '0;
            endcase
        end
    end

    assign bus.read_data = w_rdata;
    assign gpio_out      = gpio_out_q;

`ifdef TURTLE_DMEM_UART_EN
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [D_ADDR_W-1:0] C_UART_DATA = D_ADDR_W'('hF04);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    uart_state_t      uart_state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             uart_tx_q;
    logic             uart_busy_q;
    logic             w_baud_end;

    assign w_baud_end = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // tx/busy are registered so the line never glitches on decode changes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uart_state_q <= S_IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            uart_tx_q    <= 1'b1;
            uart_busy_q  <= 1'b0;
        end else begin
            case (uart_state_q)
                S_IDLE: begin
                    if (w_we && (bus.data_addr == C_UART_DATA)) begin
                        shift_q      <= bus.write_data[7:0];
                        baud_cnt_q   <= '0;
                        bit_idx_q    <= '0;
                        uart_tx_q    <= 1'b0;
                        uart_busy_q  <= 1'b1;
                        uart_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        baud_cnt_q   <= '0;
                        uart_tx_q    <= shift_q[0];
                        uart_state_q <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            uart_tx_q    <= 1'b1;
                            uart_state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            uart_tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        baud_cnt_q   <= '0;
                        uart_busy_q  <= 1'b0;
                        uart_state_q <= S_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                default: uart_state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_tx   = uart_tx_q;
    assign uart_busy = uart_busy_q;
`else
    assign uart_tx   = 1'b1;
    assign uart_busy = 1'b0;
`endif

`ifndef SYNTHESIS
    a_ram_depth: assert property (@(posedge clk) RAM_DEPTH <= 'hF00);
    a_cpb_min:   assert property (@(posedge clk) CLKS_PER_BIT >= 2);
    a_gpio_w:    assert property (@(posedge clk) GPIO_W <= DATA_W);
    a_we_known:  assert property (@(posedge clk)
                     reset_n |-> !$isunknown(bus.data_memory_write_enable));
`endif
endmodule
`default_nettype wire

// File: tb/tb_turtle_data_memory.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_turtle_data_memory : scoreboard bench for turtle_data_memory       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_turtle_data_memory;
    localparam int DW        = 8;
    localparam int AW        = 12;
    // Depth chosen so that 0xE00 is the first unmapped byte.
    localparam int RAM_DEPTH = 3584;
    localparam int CPB       = 4;
    localparam int GW        = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [GW-1:0] gpio_in;
    wire  [GW-1:0] gpio_out;
    wire           uart_tx;
    wire           uart_busy;

    always #5 clk = ~clk;

    turtle_data_memory_if #(.DATA_W(DW), .D_ADDR_W(AW)) bus ();

    turtle_data_memory #(
        .DATA_W(DW), .D_ADDR_W(AW), .RAM_DEPTH(RAM_DEPTH),
        .CLKS_PER_BIT(CPB), .GPIO_W(GW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .gpio_out(gpio_out), .gpio_in(gpio_in),
        .uart_tx(uart_tx), .uart_busy(uart_busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       exp_bit_q[$];

    task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.data_addr = a;
        bus.write_data = d;
        bus.data_memory_write_enable = 1'b1;
        @(negedge clk);
        bus.data_memory_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [7:0] d);
        bus.data_addr = a;
        bus.data_memory_write_enable = 1'b0;
        #1;
        d = bus.read_data;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [6] = '{12'hF00, 12'hF01, 12'hF02, 12'hF03, 12'hF04, 12'hF05};
        logic [7:0]  got, expv;
        reset_n = 1'b0;
        gpio_in = '0;
        bus.data_addr = '0;
        bus.write_data = '0;
        bus.data_memory_write_enable = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL rst_gpio_out: got %h expected 00", gpio_out); end
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_uart_tx: got %b expected 1", uart_tx); end
        n_checks++;
        if (uart_busy !== 1'b0) begin n_fail++; $display("FAIL rst_uart_busy: got %b expected 0", uart_busy); end
        foreach (addrs[i]) exp_q.push_back(8'h00);
        foreach (addrs[i]) begin
            bus_read(addrs[i], got);
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv) begin n_fail++; $display("FAIL rst_rd_%h: got %h expected %h", addrs[i], got, expv); end
        end
    endtask

    task automatic test_ram();
        logic [11:0] addrs [4] = '{12'h000, 12'h001, 12'h7FF, 12'hDFF};
        logic [7:0]  datas [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [11:0] unm   [4] = '{12'hE00, 12'hEFF, 12'hF06, 12'hFFF};
        logic [7:0]  got, expv;
        bus_write(12'h010, 8'hA5);
        exp_q.push_back(8'hA5);
        bus_read(12'h010, got);
        expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL ram_rd_010: got %h expected %h", got, expv); end
        // write cycle itself still shows the old contents
        @(negedge clk);
        bus.data_addr = 12'h010; bus.write_data = 8'h5A; bus.data_memory_write_enable = 1'b1;
        exp_q.push_back(8'hA5);
        #1 got = bus.read_data;
        expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL ram_old_during_wr: got %h expected %h", got, expv); end
        @(negedge clk);
        bus.data_memory_write_enable = 1'b0;
        exp_q.push_back(8'h5A);
        bus_read(12'h010, got);
        expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL ram_new_after_wr: got %h expected %h", got, expv); end
        foreach (addrs[i]) begin
            bus_write(addrs[i], datas[i]);
            exp_q.push_back(datas[i]);
        end
        foreach (unm[i]) bus_write(unm[i], 8'h77);
        foreach (addrs[i]) begin
            bus_read(addrs[i], got);
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv) begin n_fail++; $display("FAIL ram_rd_%h: got %h expected %h", addrs[i], got, expv); end
        end
        foreach (unm[i]) exp_q.push_back(8'h00);
        foreach (unm[i]) begin
            bus_read(unm[i], got);
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv) begin n_fail++; $display("FAIL unmapped_rd_%h: got %h expected %h", unm[i], got, expv); end
        end
    endtask

    task automatic test_gpio();
        logic [7:0] got, expv;
        logic [7:0] gin_exp [3] = '{8'h00, 8'h00, 8'h81};
        @(negedge clk);
        bus.data_addr = 12'hF00; bus.write_data = 8'h3C; bus.data_memory_write_enable = 1'b1;
        #1;
        n_checks++;
        if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL gpio_out_before_edge: got %h expected 00", gpio_out); end
        @(negedge clk);
        bus.data_memory_write_enable = 1'b0;
        n_checks++;
        if (gpio_out !== 8'h3C) begin n_fail++; $display("FAIL gpio_out_after_edge: got %h expected 3c", gpio_out); end
        exp_q.push_back(8'h3C);
        bus_read(12'hF00, got);
        expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL gpio_out_rd: got %h expected %h", got, expv); end
        // two synchronizer stages before the input becomes visible
        @(negedge clk);
        gpio_in = 8'h81;
        foreach (gin_exp[i]) exp_q.push_back(gin_exp[i]);
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clk);
            bus_read(12'hF01, got);
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv) begin n_fail++; $display("FAIL gpio_in_c%0d: got %h expected %h", c, got, expv); end
        end
    endtask

    task automatic test_timer();
        logic [7:0]  got, expv;
        logic [15:0] snap;
        int          k;
        k = 32'h124;
        bus_write(12'hF03, 8'h00);
        repeat (k - 2) @(negedge clk);
        bus_write(12'hF02, 8'h00);
        snap = 16'(k - 1);
        exp_q.push_back(snap[7:0]);
        exp_q.push_back(snap[15:8]);
        bus_read(12'hF02, got); expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL timer_lo: got %h expected %h", got, expv); end
        bus_read(12'hF03, got); expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL timer_hi: got %h expected %h", got, expv); end
        // run up to the top count, then snapshot two cycles later past the wrap
        k = 32'h10000;
        bus_write(12'hF03, 8'h00);
        repeat (k - 2) @(negedge clk);
        bus_write(12'hF02, 8'h00);
        snap = 16'(k - 1);
        exp_q.push_back(snap[7:0]);
        exp_q.push_back(snap[15:8]);
        bus_read(12'hF02, got); expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL timer_top_lo: got %h expected %h", got, expv); end
        bus_read(12'hF03, got); expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL timer_top_hi: got %h expected %h", got, expv); end
        bus_write(12'hF02, 8'h00);
        snap = 16'(k + 1);
        exp_q.push_back(snap[7:0]);
        exp_q.push_back(snap[15:8]);
        bus_read(12'hF02, got); expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL timer_wrap_lo: got %h expected %h", got, expv); end
        bus_read(12'hF03, got); expv = exp_q.pop_front();
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL timer_wrap_hi: got %h expected %h", got, expv); end
    endtask

`ifdef TURTLE_DMEM_UART_EN
    // Starts a frame in the current cycle and checks every cycle of it;
    // optionally attempts a second write at cycle inject_at.
    task automatic uart_frame(input logic [7:0] d, input int inject_at, input logic [7:0] inj);
        logic [9:0] frame;
        logic       cur;
        logic [7:0] got;
        frame = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) exp_bit_q.push_back(frame[i]);
        bus.data_addr = 12'hF04; bus.write_data = d; bus.data_memory_write_enable = 1'b1;
        @(negedge clk);
        bus.data_memory_write_enable = 1'b0;
        cur = 1'b1;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c % CPB == 0) cur = exp_bit_q.pop_front();
            n_checks++;
            if (uart_tx !== cur) begin n_fail++; $display("FAIL uart_tx_%h_c%0d: got %b expected %b", d, c, uart_tx, cur); end
            n_checks++;
            if (uart_busy !== 1'b1) begin n_fail++; $display("FAIL uart_busy_%h_c%0d: got %b expected 1", d, c, uart_busy); end
            if (c == inject_at) begin
                bus.data_addr = 12'hF04; bus.write_data = inj; bus.data_memory_write_enable = 1'b1;
            end else begin
                bus_read(12'hF05, got);
                n_checks++;
                if (got !== 8'h01) begin n_fail++; $display("FAIL uart_status_%h_c%0d: got %h expected 01", d, c, got); end
            end
            @(negedge clk);
            bus.data_memory_write_enable = 1'b0;
        end
        n_checks++;
        if (uart_busy !== 1'b0 || uart_tx !== 1'b1) begin
            n_fail++; $display("FAIL uart_end_%h: got busy=%b tx=%b expected busy=0 tx=1", d, uart_busy, uart_tx);
        end
    endtask

    task automatic test_uart();
        logic [7:0] got;
        @(negedge clk);
        uart_frame(8'h55, -1, 8'h00);
        uart_frame(8'hA3, 10, 8'hFF);
        for (int c = 0; c < 3 * CPB; c++) begin
            @(negedge clk);
            n_checks++;
            if (uart_busy !== 1'b0 || uart_tx !== 1'b1) begin
                n_fail++; $display("FAIL uart_no_second_frame_c%0d: got busy=%b tx=%b expected busy=0 tx=1", c, uart_busy, uart_tx);
            end
        end
        bus_read(12'hF04, got);
        n_checks++;
        if (got !== 8'h00) begin n_fail++; $display("FAIL uart_data_rd: got %h expected 00", got); end
    endtask
`else
    task automatic test_uart_disabled();
        logic [7:0] got;
        bus_write(12'hF04, 8'h55);
        for (int c = 0; c < 5 * CPB; c++) begin
            n_checks++;
            if (uart_busy !== 1'b0 || uart_tx !== 1'b1) begin
                n_fail++; $display("FAIL uart_off_c%0d: got busy=%b tx=%b expected busy=0 tx=1", c, uart_busy, uart_tx);
            end
            @(negedge clk);
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        bus_read(12'hF05, got);
        n_checks++;
        if (got !== exp_q.pop_front()) begin n_fail++; $display("FAIL uart_off_status: got %h expected 00", got); end
        bus_read(12'hF04, got);
        n_checks++;
        if (got !== exp_q.pop_front()) begin n_fail++; $display("FAIL uart_off_data: got %h expected 00", got); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        n_checks++;
        if (gpio_out !== 8'h3C) begin n_fail++; $display("FAIL pre_reset_gpio: got %h expected 3c", gpio_out); end
`ifdef TURTLE_DMEM_UART_EN
        bus_write(12'hF04, 8'hF0);
        repeat (2 * CPB + 1) @(negedge clk);
        n_checks++;
        if (uart_busy !== 1'b1) begin n_fail++; $display("FAIL mid_frame_busy: got %b expected 1", uart_busy); end
`endif
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b1 || uart_busy !== 1'b0 || gpio_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid: got tx=%b busy=%b gpio=%h expected tx=1 busy=0 gpio=00", uart_tx, uart_busy, gpio_out);
        end
        reset_n = 1'b1;
        repeat (CPB * 2) @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b1 || uart_busy !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_idle: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, uart_busy);
        end
        bus_read(12'hF02, got);
        n_checks++;
        if (got !== 8'h00) begin n_fail++; $display("FAIL after_reset_snap: got %h expected 00", got); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        gpio_in = '0;
        bus.data_addr = '0;
        bus.write_data = '0;
        bus.data_memory_write_enable = 1'b0;
        test_reset();
        test_ram();
        test_gpio();
        test_timer();
`ifdef TURTLE_DMEM_UART_EN
        test_uart();
`else
        test_uart_disabled();
`endif
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
